// File: rtl/dft_run_seq.sv
// Run sequencer for the DFT engine: walks every frequency bin, fetching the
// sample buffer in bursts for each bin and writing back one (re, im) pair.
module dft_run_seq #(
    parameter int unsigned ADDR_WIDTH      = 24,
    parameter int unsigned BURST_LEN_ORDER = 4,
    parameter int unsigned NLOG_MAX        = 12
) (
    input  logic                  AXI_S_ACLK,
    input  logic                  AXI_S_ARESETn,
    input  logic                  CFG_START,
    input  logic                  CFG_ABORT,
    input  logic [3:0]            CFG_NLOG,
    input  logic [ADDR_WIDTH-1:0] CFG_SRC,
    input  logic [ADDR_WIDTH-1:0] CFG_DST,
    input  logic                  IRQ_CLR,
    output logic                  ENG_CLEAR,
    output logic [NLOG_MAX-1:0]   ENG_K,
    output logic [3:0]            ENG_NLOG,
    input  logic                  ENG_RES_VALID,
    output logic                  MRD_VALID,
    input  logic                  MRD_READY,
    output logic [ADDR_WIDTH-1:0] MRD_ADDR,
    input  logic                  MRD_DONE,
    output logic                  MWR_VALID,
    input  logic                  MWR_READY,
    output logic [ADDR_WIDTH-1:0] MWR_ADDR,
    input  logic                  MWR_DONE,
    output logic                  BUSY,
    output logic                  ERR,
    output logic                  ABORTED,
    output logic                  INTERRUPT
);

    // Burst counter must hold the full burst count of the largest transform.
    localparam int unsigned BCNT_W      = NLOG_MAX - BURST_LEN_ORDER + 1;
    localparam int unsigned BURST_SHIFT = BURST_LEN_ORDER + 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RD_REQ,
        RD_WAIT,
        RES_WAIT,
        WR_REQ,
        WR_WAIT,
        NEXT
    } state_t;

    state_t                state_q, state_d;
    logic [NLOG_MAX-1:0]   k_q, k_d;
    logic [BCNT_W-1:0]     b_q, b_d;
    logic [3:0]            nlog_q, nlog_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic                  abort_pend_q, abort_pend_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  aborted_q, aborted_d;
    logic                  irq_q, irq_d;
    logic                  eng_clear_q, eng_clear_d;
    logic                  mrd_valid_q, mrd_valid_d;
    logic [ADDR_WIDTH-1:0] mrd_addr_q, mrd_addr_d;
    logic                  mwr_valid_q, mwr_valid_d;
    logic [ADDR_WIDTH-1:0] mwr_addr_q, mwr_addr_d;

    logic                  start_ok_c;
    logic                  abort_c;
    logic [BCNT_W-1:0]     b_inc_c;
    logic [BCNT_W-1:0]     b_total_c;
    logic [NLOG_MAX-1:0]   k_last_c;

    // Start legality, bursts per bin and last bin index of the latched size
    assign start_ok_c = (CFG_NLOG >= 4'(BURST_LEN_ORDER)) && (CFG_NLOG <= 4'(NLOG_MAX));
    assign b_inc_c    = b_q + BCNT_W'(1);
    assign b_total_c  = BCNT_W'(1) << (nlog_q - 4'(BURST_LEN_ORDER));
    assign k_last_c   = (NLOG_MAX'(1) << nlog_q) - NLOG_MAX'(1);

    // State, run context and registered outputs
    always_ff @(posedge AXI_S_ACLK or negedge AXI_S_ARESETn) begin
        if (!AXI_S_ARESETn) begin
            state_q      <= IDLE;
            k_q          <= '0;
            b_q          <= '0;
            nlog_q       <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            irq_q        <= 1'b0;
            eng_clear_q  <= 1'b0;
            mrd_valid_q  <= 1'b0;
            mrd_addr_q   <= '0;
            mwr_valid_q  <= 1'b0;
            mwr_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            b_q          <= b_d;
            nlog_q       <= nlog_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            aborted_q    <= aborted_d;
            irq_q        <= irq_d;
            eng_clear_q  <= eng_clear_d;
            mrd_valid_q  <= mrd_valid_d;
            mrd_addr_q   <= mrd_addr_d;
            mwr_valid_q  <= mwr_valid_d;
            mwr_addr_q   <= mwr_addr_d;
        end
    end

    // Next state, run context and next output values
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        b_d          = b_q;
        nlog_d       = nlog_q;
        src_d        = src_q;
        dst_d        = dst_q;
        abort_pend_d = abort_pend_q;
        busy_d       = busy_q;
        err_d        = err_q;
        aborted_d    = aborted_q;
        irq_d        = irq_q;
        abort_c      = 1'b0;

        if (IRQ_CLR) begin
            irq_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (CFG_START) begin
                    if (start_ok_c) begin
                        nlog_d       = CFG_NLOG;
                        src_d        = CFG_SRC;
                        dst_d        = CFG_DST;
                        k_d          = '0;
                        b_d          = '0;
                        err_d        = 1'b0;
                        aborted_d    = 1'b0;
                        abort_pend_d = 1'b0;
                        busy_d       = 1'b1;
                        irq_d        = 1'b0;
                        state_d      = CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (CFG_ABORT) begin
                    abort_c = 1'b1;
                end else begin
                    b_d     = '0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                // An accept wins over a coincident abort so the read is tracked.
                if (MRD_READY) begin
                    state_d = RD_WAIT;
                    if (CFG_ABORT) begin
                        abort_pend_d = 1'b1;
                    end
                end else if (CFG_ABORT) begin
                    abort_c = 1'b1;
                end
            end
            RD_WAIT: begin
                if (CFG_ABORT) begin
                    abort_pend_d = 1'b1;
                end
                if (MRD_DONE) begin
                    if (abort_pend_q || CFG_ABORT) begin
                        abort_c = 1'b1;
                    end else begin
                        b_d     = b_inc_c;
                        state_d = (b_inc_c == b_total_c) ? RES_WAIT : RD_REQ;
                    end
                end
            end
            RES_WAIT: begin
                if (CFG_ABORT) begin
                    abort_c = 1'b1;
                end else if (ENG_RES_VALID) begin
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (MWR_READY) begin
                    state_d = WR_WAIT;
                    if (CFG_ABORT) begin
                        abort_pend_d = 1'b1;
                    end
                end else if (CFG_ABORT) begin
                    abort_c = 1'b1;
                end
            end
            WR_WAIT: begin
                if (CFG_ABORT) begin
                    abort_pend_d = 1'b1;
                end
                if (MWR_DONE) begin
                    if (abort_pend_q || CFG_ABORT) begin
                        abort_c = 1'b1;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (CFG_ABORT) begin
                    abort_c = 1'b1;
                end else if (k_q == k_last_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    irq_d   = 1'b1;
                end else begin
                    k_d     = k_q + NLOG_MAX'(1);
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_c) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
        end

        eng_clear_d = (state_d == CLEAR);
        mrd_valid_d = (state_d == RD_REQ);
        mwr_valid_d = (state_d == WR_REQ);
        mrd_addr_d  = mrd_valid_d ? (src_d + (ADDR_WIDTH'(b_d) << BURST_SHIFT)) : '0;
        mwr_addr_d  = mwr_valid_d ? (dst_d + (ADDR_WIDTH'(k_d) << 3)) : '0;
    end

    assign ENG_CLEAR = eng_clear_q;
    assign ENG_K     = k_q;
    assign ENG_NLOG  = nlog_q;
    assign MRD_VALID = mrd_valid_q;
    assign MRD_ADDR  = mrd_addr_q;
    assign MWR_VALID = mwr_valid_q;
    assign MWR_ADDR  = mwr_addr_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;
    assign ABORTED   = aborted_q;
    assign INTERRUPT = irq_q;

endmodule

// File: tb/tb_dft_run_seq.sv
// Directed bench for dft_run_seq with a memory/engine responder model.
module tb_dft_run_seq;

    logic        AXI_S_ACLK    = 1'b0;
    logic        AXI_S_ARESETn = 1'b0;
    logic        CFG_START     = 1'b0;
    logic        CFG_ABORT     = 1'b0;
    logic [3:0]  CFG_NLOG      = 4'd0;
    logic [23:0] CFG_SRC       = 24'd0;
    logic [23:0] CFG_DST       = 24'd0;
    logic        IRQ_CLR       = 1'b0;
    logic        ENG_CLEAR;
    logic [11:0] ENG_K;
    logic [3:0]  ENG_NLOG;
    logic        ENG_RES_VALID = 1'b0;
    logic        MRD_VALID;
    logic        MRD_READY     = 1'b0;
    logic [23:0] MRD_ADDR;
    logic        MRD_DONE      = 1'b0;
    logic        MWR_VALID;
    logic        MWR_READY     = 1'b0;
    logic [23:0] MWR_ADDR;
    logic        MWR_DONE      = 1'b0;
    logic        BUSY;
    logic        ERR;
    logic        ABORTED;
    logic        INTERRUPT;

    dft_run_seq dut (
        .AXI_S_ACLK    (AXI_S_ACLK),
        .AXI_S_ARESETn (AXI_S_ARESETn),
        .CFG_START     (CFG_START),
        .CFG_ABORT     (CFG_ABORT),
        .CFG_NLOG      (CFG_NLOG),
        .CFG_SRC       (CFG_SRC),
        .CFG_DST       (CFG_DST),
        .IRQ_CLR       (IRQ_CLR),
        .ENG_CLEAR     (ENG_CLEAR),
        .ENG_K         (ENG_K),
        .ENG_NLOG      (ENG_NLOG),
        .ENG_RES_VALID (ENG_RES_VALID),
        .MRD_VALID     (MRD_VALID),
        .MRD_READY     (MRD_READY),
        .MRD_ADDR      (MRD_ADDR),
        .MRD_DONE      (MRD_DONE),
        .MWR_VALID     (MWR_VALID),
        .MWR_READY     (MWR_READY),
        .MWR_ADDR      (MWR_ADDR),
        .MWR_DONE      (MWR_DONE),
        .BUSY          (BUSY),
        .ERR           (ERR),
        .ABORTED       (ABORTED),
        .INTERRUPT     (INTERRUPT)
    );

    always #5 AXI_S_ACLK = ~AXI_S_ACLK;

    int checks   = 0;
    int failures = 0;

    // Knobs set by the directed sequence, read by the responder
    int   eng_bursts    = 1;
    logic eng_hold      = 1'b0;
    logic wr_hold       = 1'b0;
    int   mrd_stall_len = 0;

    // Responder state and transaction logs
    int          rd_cnt = 0, wr_cnt = 0, res_cnt = 0, rd_done_bin = 0;
    int          rd_done_total = 0, wr_done_total = 0;
    int          irq_rises = 0, irq_wdone = 0, stall_done = 0;
    logic        stall_seen = 1'b0, stall_bad = 1'b0, irq_prev = 1'b0;
    logic [23:0] stall_addr = 24'd0;
    logic [23:0] rd_q[$];
    logic [23:0] wr_q[$];
    logic [11:0] k_q[$];

    // Memory masters and engine: READY high unless stalled, DONE 3 cycles after accept
    always @(negedge AXI_S_ACLK) begin
        if (!AXI_S_ARESETn) begin
            rd_cnt        = 0;
            wr_cnt        = 0;
            res_cnt       = 0;
            rd_done_bin   = 0;
            irq_prev      = 1'b0;
            MRD_READY     = 1'b0;
            MRD_DONE      = 1'b0;
            MWR_READY     = 1'b0;
            MWR_DONE      = 1'b0;
            ENG_RES_VALID = 1'b0;
        end else begin
            if (INTERRUPT && !irq_prev) begin
                irq_rises++;
                irq_wdone = wr_done_total;
            end
            irq_prev = INTERRUPT;
            if (ENG_CLEAR) begin
                rd_done_bin = 0;
                k_q.push_back(ENG_K);
            end
            ENG_RES_VALID = 1'b0;
            if (res_cnt != 0) begin
                res_cnt--;
                if (res_cnt == 0) ENG_RES_VALID = 1'b1;
            end
            MRD_DONE = 1'b0;
            if (rd_cnt != 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    MRD_DONE = 1'b1;
                    rd_done_total++;
                    rd_done_bin++;
                    if (rd_done_bin == eng_bursts && !eng_hold) res_cnt = 2;
                end
            end
            if (MRD_VALID && stall_done < mrd_stall_len) begin
                if (stall_seen && MRD_ADDR != stall_addr) stall_bad = 1'b1;
                stall_seen = 1'b1;
                stall_addr = MRD_ADDR;
                MRD_READY  = 1'b0;
                stall_done++;
            end else begin
                if (stall_seen && stall_done < mrd_stall_len && !MRD_VALID) stall_bad = 1'b1;
                MRD_READY = 1'b1;
                if (MRD_VALID) begin
                    rd_q.push_back(MRD_ADDR);
                    rd_cnt = 3;
                end
            end
            MWR_DONE = 1'b0;
            if (wr_cnt != 0) begin
                wr_cnt--;
                if (wr_cnt == 0) begin
                    MWR_DONE = 1'b1;
                    wr_done_total++;
                end
            end
            MWR_READY = !wr_hold;
            if (MWR_VALID && !wr_hold) begin
                wr_q.push_back(MWR_ADDR);
                wr_cnt = 3;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{ENG_CLEAR, ENG_K, ENG_NLOG, MRD_VALID, MRD_ADDR, MWR_VALID, MWR_ADDR,
                 BUSY, ERR, ABORTED, INTERRUPT};
    endfunction

    task automatic start_run(input logic [3:0] nlog, input logic [23:0] src, input logic [23:0] dst);
        @(negedge AXI_S_ACLK);
        CFG_NLOG  = nlog;
        CFG_SRC   = src;
        CFG_DST   = dst;
        CFG_START = 1'b1;
        @(negedge AXI_S_ACLK);
        CFG_START = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (BUSY && n < maxc) begin
            @(negedge AXI_S_ACLK);
            n++;
        end
        #1;
        check(tag, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int rb, wb, kb, ib, wdb, rdb, n;

        // Reset state
        repeat (3) @(negedge AXI_S_ACLK);
        check("reset_outputs", 32'(any_out()), 32'd0);
        AXI_S_ARESETn = 1'b1;

        // Run 1: N=16, one burst per bin
        rb = rd_q.size(); wb = wr_q.size(); kb = k_q.size(); ib = irq_rises; wdb = wr_done_total;
        eng_bursts = 1;
        start_run(4'd4, 24'h001000, 24'h002000);
        check("r1_busy", 32'(BUSY), 32'd1);
        check("r1_eng_clear", 32'(ENG_CLEAR), 32'd1);
        check("r1_eng_k0", 32'(ENG_K), 32'd0);
        check("r1_eng_nlog", 32'(ENG_NLOG), 32'd4);
        wait_idle("r1_done", 3000);
        check("r1_nreads", 32'(rd_q.size() - rb), 32'd16);
        check("r1_nwrites", 32'(wr_q.size() - wb), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("r1_rd%0d", i), 32'(rd_q[rb + i]), 32'h1000);
            check($sformatf("r1_wr%0d", i), 32'(wr_q[wb + i]), 32'h2000 + 32'(8 * i));
            check($sformatf("r1_k%0d", i), 32'(k_q[kb + i]), 32'(i));
        end
        check("r1_irq_rises", 32'(irq_rises - ib), 32'd1);
        check("r1_irq_after_wdone", 32'(irq_wdone - wdb), 32'd16);
        check("r1_irq", 32'(INTERRUPT), 32'd1);
        check("r1_aborted", 32'(ABORTED), 32'd0);

        // Run 2: N=64, four bursts per bin, first request stalled 5 cycles
        rb = rd_q.size(); wb = wr_q.size(); kb = k_q.size();
        eng_bursts = 4;
        mrd_stall_len = 5;
        start_run(4'd6, 24'h001000, 24'h002000);
        check("r2_irq_cleared_by_start", 32'(INTERRUPT), 32'd0);
        wait_idle("r2_done", 20000);
        check("r2_stall_cycles", 32'(stall_done), 32'd5);
        check("r2_stall_stable", 32'(stall_bad), 32'd0);
        check("r2_nreads", 32'(rd_q.size() - rb), 32'd256);
        check("r2_rd0", 32'(rd_q[rb + 0]), 32'h1000);
        check("r2_rd1", 32'(rd_q[rb + 1]), 32'h1040);
        check("r2_rd2", 32'(rd_q[rb + 2]), 32'h1080);
        check("r2_rd3", 32'(rd_q[rb + 3]), 32'h10C0);
        check("r2_rd4", 32'(rd_q[rb + 4]), 32'h1000);
        check("r2_nwrites", 32'(wr_q.size() - wb), 32'd64);
        check("r2_last_wr", 32'(wr_q[wb + 63]), 32'h21F8);
        check("r2_last_k", 32'(k_q[kb + 63]), 32'd63);
        check("r2_irq", 32'(INTERRUPT), 32'd1);

        // Illegal sizes are rejected
        rb = rd_q.size();
        eng_bursts = 1;
        start_run(4'd3, 24'h001000, 24'h002000);
        check("e3_err", 32'(ERR), 32'd1);
        check("e3_busy", 32'(BUSY), 32'd0);
        start_run(4'd13, 24'h001000, 24'h002000);
        check("e13_err", 32'(ERR), 32'd1);
        check("e13_busy", 32'(BUSY), 32'd0);
        repeat (4) @(negedge AXI_S_ACLK);
        check("e_no_reads", 32'(rd_q.size() - rb), 32'd0);
        check("e_no_valid", 32'(MRD_VALID), 32'd0);

        // Valid start clears ERR; start while busy ignored; IRQ_CLR coincident with completion
        rb = rd_q.size(); wb = wr_q.size(); wdb = wr_done_total;
        start_run(4'd4, 24'h001000, 24'h002000);
        check("v_err_cleared", 32'(ERR), 32'd0);
        check("v_busy", 32'(BUSY), 32'd1);
        repeat (3) @(negedge AXI_S_ACLK);
        CFG_NLOG  = 4'd5;
        CFG_SRC   = 24'h005000;
        CFG_DST   = 24'h006000;
        CFG_START = 1'b1;
        @(negedge AXI_S_ACLK);
        CFG_START = 1'b0;
        n = 0;
        while (n < 3000) begin
            @(posedge AXI_S_ACLK);
            #1;
            if (MWR_DONE && (wr_done_total - wdb) == 16) break;
            n++;
        end
        check("v_last_done_seen", 32'(n < 3000), 32'd1);
        @(negedge AXI_S_ACLK);
        IRQ_CLR = 1'b1;
        check("v_busy_in_next", 32'(BUSY), 32'd1);
        @(negedge AXI_S_ACLK);
        IRQ_CLR = 1'b0;
        check("v_irq_set_wins", 32'(INTERRUPT), 32'd1);
        check("v_idle", 32'(BUSY), 32'd0);
        @(negedge AXI_S_ACLK);
        IRQ_CLR = 1'b1;
        @(negedge AXI_S_ACLK);
        IRQ_CLR = 1'b0;
        check("v_irq_cleared", 32'(INTERRUPT), 32'd0);
        check("v_nreads", 32'(rd_q.size() - rb), 32'd16);
        check("v_rd_last", 32'(rd_q[rb + 15]), 32'h1000);
        check("v_nwrites", 32'(wr_q.size() - wb), 32'd16);
        check("v_wr_last", 32'(wr_q[wb + 15]), 32'h2078);
        check("v_nlog_kept", 32'(ENG_NLOG), 32'd4);

        // Abort while bin 2's read is outstanding
        rb = rd_q.size(); wb = wr_q.size(); ib = irq_rises;
        start_run(4'd4, 24'h001000, 24'h002000);
        n = 0;
        while ((rd_q.size() - rb) < 3 && n < 500) begin
            @(posedge AXI_S_ACLK);
            #1;
            n++;
        end
        check("a_bin2_read_issued", 32'(rd_q.size() - rb), 32'd3);
        @(negedge AXI_S_ACLK);
        CFG_ABORT = 1'b1;
        @(negedge AXI_S_ACLK);
        CFG_ABORT = 1'b0;
        check("a_busy_until_done", 32'(BUSY), 32'd1);
        wait_idle("a_done", 100);
        repeat (5) @(negedge AXI_S_ACLK);
        check("a_nreads", 32'(rd_q.size() - rb), 32'd3);
        check("a_nwrites", 32'(wr_q.size() - wb), 32'd2);
        check("a_aborted", 32'(ABORTED), 32'd1);
        check("a_irq", 32'(INTERRUPT), 32'd0);
        check("a_irq_rises", 32'(irq_rises - ib), 32'd0);

        // Abort while waiting for the engine result
        wb = wr_q.size(); rdb = rd_done_total;
        eng_hold = 1'b1;
        start_run(4'd4, 24'h001000, 24'h002000);
        check("rw_aborted_cleared", 32'(ABORTED), 32'd0);
        n = 0;
        while ((rd_done_total - rdb) < 1 && n < 500) begin
            @(posedge AXI_S_ACLK);
            #1;
            n++;
        end
        @(negedge AXI_S_ACLK);
        CFG_ABORT = 1'b1;
        @(negedge AXI_S_ACLK);
        CFG_ABORT = 1'b0;
        check("rw_idle_next_cycle", 32'(BUSY), 32'd0);
        check("rw_aborted", 32'(ABORTED), 32'd1);
        check("rw_irq", 32'(INTERRUPT), 32'd0);
        repeat (3) @(negedge AXI_S_ACLK);
        check("rw_no_write", 32'(wr_q.size() - wb), 32'd0);
        eng_hold = 1'b0;

        // Source address wrap, then asynchronous reset while a write is pending
        rb = rd_q.size();
        eng_bursts = 2;
        wr_hold = 1'b1;
        start_run(4'd5, 24'hFFFFF0, 24'h003000);
        n = 0;
        while ((rd_q.size() - rb) < 2 && n < 500) begin
            @(posedge AXI_S_ACLK);
            #1;
            n++;
        end
        check("w_rd0", 32'(rd_q[rb + 0]), 32'hFFFFF0);
        check("w_rd1_wrapped", 32'(rd_q[rb + 1]), 32'h000030);
        n = 0;
        while (!MWR_VALID && n < 500) begin
            @(negedge AXI_S_ACLK);
            n++;
        end
        check("w_wr_valid", 32'(MWR_VALID), 32'd1);
        check("w_wr_addr", 32'(MWR_ADDR), 32'h003000);
        #2;
        AXI_S_ARESETn = 1'b0;
        #1;
        check("w_async_reset", 32'(any_out()), 32'd0);
        @(negedge AXI_S_ACLK);
        wr_hold = 1'b0;
        AXI_S_ARESETn = 1'b1;
        repeat (3) @(negedge AXI_S_ACLK);
        check("w_post_reset_idle", 32'(any_out()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dft_run_seq.md
Name: dft_run_seq

Overview:
- Run sequencer for the DFT engine behind the AXI-Lite slave.
- Once started by a register write, it steps the frequency index k over all bins of an N-point transform.
- For each bin it clears the engine accumulator, schedules sample burst reads from memory and waits for the engine result. It then schedules a two-word result write (re, im).
- Raises INTERRUPT at run completion; the register file owns configuration values and decodes them into CFG_* pulses.

Parameters:
ADDR_WIDTH, 24, byte address width of memory request ports
BURST_LEN_ORDER, 4, log2 words per read burst (words are 32-bit)
NLOG_MAX, 12, largest legal log2(N)

Ports:
AXI_S_ACLK  in  1  clock
AXI_S_ARESETn  in  1  asynchronous active-low reset
CFG_START  in  1  one-cycle start pulse
CFG_ABORT  in  1  one-cycle abort pulse
CFG_NLOG  in  4  log2(N), sampled at start
CFG_SRC  in  ADDR_WIDTH  sample buffer base (byte, 4-aligned), sampled at start
CFG_DST  in  ADDR_WIDTH  result buffer base (byte, 8-aligned), sampled at start
IRQ_CLR  in  1  clears INTERRUPT
ENG_CLEAR  out  1  one-cycle pulse: zero accumulator, load ENG_K
ENG_K  out  NLOG_MAX  current bin index
ENG_NLOG  out  4  latched log2(N)
ENG_RES_VALID  in  1  pulse: bin result ready in engine
MRD_VALID  out  1  burst read request
MRD_READY  in  1  read request accepted
MRD_ADDR  out  ADDR_WIDTH  burst start address
MRD_DONE  in  1  pulse: last beat of burst delivered to engine
MWR_VALID  out  1  result write request (2 words at MWR_ADDR)
MWR_READY  in  1  write request accepted
MWR_ADDR  out  ADDR_WIDTH  result address
MWR_DONE  in  1  pulse: write response received
BUSY  out  1  run in progress
ERR  out  1  last start rejected
ABORTED  out  1  last run ended by abort
INTERRUPT  out  1  level interrupt

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States: IDLE, CLEAR, RD_REQ, RD_WAIT, RES_WAIT, WR_REQ, WR_WAIT, NEXT.
- IDLE, CFG_START:
  - If BURST_LEN_ORDER <= CFG_NLOG <= NLOG_MAX: latch NLOG/SRC/DST; k=0; clear ERR and ABORTED; BUSY=1; clear INTERRUPT; go to CLEAR next cycle.
  - Otherwise: ERR=1 and stay in IDLE.
- CFG_START while BUSY is ignored.
- CLEAR: ENG_CLEAR=1 for exactly one cycle with ENG_K=k; burst count b=0; go to RD_REQ.
- RD_REQ: MRD_VALID=1 with MRD_ADDR = SRC + b*(4<<BURST_LEN_ORDER).
  - MRD_VALID and MRD_ADDR hold stable until MRD_READY.
  - Accept cycle goes to RD_WAIT.
- Only one read outstanding at a time.
- RD_WAIT, on MRD_DONE: b++.
  - If b reaches 2^(NLOG-BURST_LEN_ORDER), go to RES_WAIT; otherwise go to RD_REQ.
  - MRD_DONE in any other state is ignored.
- RES_WAIT, on ENG_RES_VALID: go to WR_REQ.
- WR_REQ: MWR_VALID=1 with MWR_ADDR = DST + 8*k, held until MWR_READY, then go to WR_WAIT.
- WR_WAIT, on MWR_DONE: go to NEXT.
- NEXT: if k == N-1, go to IDLE, BUSY=0, INTERRUPT=1. Otherwise k++ and go to CLEAR.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
- Per-bin overhead: CLEAR + NEXT plus one cycle per handshake stage.
- The engine's latency is unbounded; the sequencer just waits.
- CFG_ABORT in CLEAR, RD_REQ, RES_WAIT, WR_REQ or NEXT: go to IDLE next cycle; BUSY=0; ABORTED=1; no INTERRUPT.
- In RD_REQ and WR_REQ, the request drops only if not accepted that same cycle. If MRD_READY/MWR_READY coincides with abort, treat the request as accepted and take the WAIT path below.
- CFG_ABORT in RD_WAIT or WR_WAIT: latch abort-pending; no new requests.
  - On the awaited DONE, go to IDLE; ABORTED=1.
  - Outstanding transactions are never orphaned.
- CFG_ABORT in IDLE has no effect.
- INTERRUPT: set at run completion, cleared by IRQ_CLR or an accepted start.
  - Set and IRQ_CLR in the same cycle: set wins.
- Async reset mid-run: immediate return to reset values. The external masters are reset by the same net.

Test Plan:
- NLOG=4, BURST_LEN_ORDER=4, SRC=0x1000, DST=0x2000, READY tied 1, DONE 3 cycles after accept -> 16 bins.
  - One read per bin at 0x1000; writes at 0x2000..0x2078 step 8; ENG_K 0..15.
  - INTERRUPT rises once after the last MWR_DONE.
- NLOG=6 -> 4 bursts per bin at 0x1000/0x1040/0x1080/0x10C0.
  - MRD_READY stalled 5 cycles: MRD_VALID and MRD_ADDR stay stable through the stall.
- CFG_NLOG=3 and CFG_NLOG=13 -> ERR=1; BUSY stays 0; no requests issued.
  - A following valid start clears ERR.
- CFG_ABORT in RD_WAIT of bin 2 -> no further MRD_VALID; IDLE after MRD_DONE; ABORTED=1; INTERRUPT=0.
  - CFG_ABORT in RES_WAIT -> IDLE next cycle.
- IRQ_CLR coincident with completion -> INTERRUPT=1; IRQ_CLR next cycle -> INTERRUPT=0.
  - CFG_START while BUSY -> ignored; run result unchanged.
- SRC=0xFFFFF0, NLOG=5 -> second burst address is 0x000030 (wrap).
  - ARESETn asserted mid-WR_REQ -> all outputs 0 asynchronously.
